// File: rtl/adc_fill_reader.sv
// adc_fill_reader
// ---------------------------------------------------------------------------
// Reads ADC fills back out of the DDR3 read FIFO (first-word-fall-through) and
// serialises every 128-bit word into four 32-bit beats for the Master FPGA link.
//
// A fill is one header word, then num_fill_bursts data words, then one trailer
// word. The trailer holds the XOR of all data words. The header fields are
// latched on the header pop. The trailer is checked against the running XOR
// of the data words.
//
// Handshakes (valid/ready):
//   - Input:  a word moves when in_valid=1 and in_rd=1 in the same cycle.
//             in_rd is combinational from state, holding-register occupancy
//             and the output handshake, so words follow each other with no
//             bubble.
//   - Output: a beat moves when out_valid=1 and out_ready=1 in the same cycle.
//             While out_ready=0, out_dat and out_valid hold steady.
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   rd_abort        synchronous abort; same effect as reset, highest priority
//   in_dat/in_valid FIFO head word and FIFO-not-empty
//   in_rd           pop strobe
//   out_dat/out_valid/out_ready  32-bit beat stream, LSW of each word first
//   fill_num, burst_start_adr, num_fill_bursts, fill_type, channel_tag
//                   header fields, latched on the header pop
//   hdr_valid       pulses for one cycle after the header pop
//   fill_done       pulses for one cycle after the trailer's last beat
//   checksum_err    valid with fill_done; held until the next header pop
//   reader_idle     the reader is waiting for a new fill
// ---------------------------------------------------------------------------
module adc_fill_reader #(
    parameter bit CHECK_EN = 1'b1,
    parameter bit FWD_HDR  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_abort,
    input  logic [127:0] in_dat,
    input  logic         in_valid,
    output logic         in_rd,
    output logic [31:0]  out_dat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [23:0]  fill_num,
    output logic [22:0]  burst_start_adr,
    output logic [23:0]  num_fill_bursts,
    output logic [1:0]   fill_type,
    output logic [15:0]  channel_tag,
    output logic         hdr_valid,
    output logic         fill_done,
    output logic         checksum_err,
    output logic         reader_idle
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [1:0]    beat_q, beat_d;
    logic [127:0]  acc_q, acc_d;
    logic [23:0]   cnt_q, cnt_d;
    logic          trl_popped_q, trl_popped_d;
    logic          csum_bad_q, csum_bad_d;
    logic [23:0]   fill_num_q, fill_num_d;
    logic [22:0]   adr_q, adr_d;
    logic [23:0]   nfb_q, nfb_d;
    logic [1:0]    type_q, type_d;
    logic [15:0]   tag_q, tag_d;
    logic          hdr_valid_q, hdr_valid_d;
    logic          fill_done_q, fill_done_d;
    logic          checksum_err_q, checksum_err_d;

    logic          pop_state;
    logic          xfer;
    logic          last_xfer;
    logic          pop;
    logic          load;

    // The CSUM state may pop only once: the trailer. After that it waits for
    // the trailer's beats to drain.
    always_comb begin
        pop_state = 1'b0;
        case (state_q)
            S_HDR, S_DATA: pop_state = 1'b1;
            S_CSUM:        pop_state = ~trl_popped_q;
            default:       pop_state = 1'b0;
        endcase
    end

    assign xfer      = hold_full_q & out_ready;
    assign last_xfer = xfer & (beat_q == 2'd3);
    // A pop may refill the holding register in the same cycle that its last
    // beat leaves, so a steady out_ready gives one word every four cycles.
    assign in_rd     = in_valid & pop_state & ~reset & ~rd_abort &
                       (~hold_full_q | last_xfer);
    assign pop       = in_rd;
    // With FWD_HDR=0 the header is parsed but never serialised.
    assign load      = pop & ((state_q != S_HDR) | FWD_HDR);

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        beat_d         = beat_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        trl_popped_d   = trl_popped_q;
        csum_bad_d     = csum_bad_q;
        fill_num_d     = fill_num_q;
        adr_d          = adr_q;
        nfb_d          = nfb_q;
        type_d         = type_q;
        tag_d          = tag_q;
        hdr_valid_d    = 1'b0;
        fill_done_d    = 1'b0;
        checksum_err_d = checksum_err_q;

        // Serialiser: the beat index wraps 3 -> 0 on the last beat of a word.
        if (xfer) begin
            beat_d = beat_q + 2'd1;
        end
        if (last_xfer) begin
            hold_full_d = 1'b0;
        end
        if (load) begin
            hold_d      = in_dat;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (pop) begin
                    fill_num_d     = in_dat[23:0];
                    adr_d          = in_dat[46:24];
                    nfb_d          = in_dat[70:47];
                    type_d         = in_dat[72:71];
                    tag_d          = in_dat[88:73];
                    hdr_valid_d    = 1'b1;
                    cnt_d          = in_dat[70:47];
                    acc_d          = '0;
                    trl_popped_d   = 1'b0;
                    csum_bad_d     = 1'b0;
                    checksum_err_d = 1'b0;
                    state_d        = (in_dat[70:47] != 24'd0) ? S_DATA : S_CSUM;
                end
            end
            S_DATA: begin
                if (pop) begin
                    acc_d = acc_q ^ in_dat;
                    if (cnt_q != 24'd0) begin
                        cnt_d = cnt_q - 24'd1;
                    end
                    if (cnt_q == 24'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                // The trailer is compared but not folded into the accumulator.
                if (pop) begin
                    trl_popped_d = 1'b1;
                    csum_bad_d   = (in_dat != acc_q);
                end
                if (trl_popped_q && last_xfer) begin
                    state_d        = S_DONE;
                    fill_done_d    = 1'b1;
                    checksum_err_d = CHECK_EN & csum_bad_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || rd_abort) begin
            state_q        <= S_IDLE;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            beat_q         <= 2'd0;
            acc_q          <= '0;
            cnt_q          <= '0;
            trl_popped_q   <= 1'b0;
            csum_bad_q     <= 1'b0;
            fill_num_q     <= '0;
            adr_q          <= '0;
            nfb_q          <= '0;
            type_q         <= '0;
            tag_q          <= '0;
            hdr_valid_q    <= 1'b0;
            fill_done_q    <= 1'b0;
            checksum_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            beat_q         <= beat_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            trl_popped_q   <= trl_popped_d;
            csum_bad_q     <= csum_bad_d;
            fill_num_q     <= fill_num_d;
            adr_q          <= adr_d;
            nfb_q          <= nfb_d;
            type_q         <= type_d;
            tag_q          <= tag_d;
            hdr_valid_q    <= hdr_valid_d;
            fill_done_q    <= fill_done_d;
            checksum_err_q <= checksum_err_d;
        end
    end

    always_comb begin
        case (beat_q)
            2'd0:    out_dat = hold_q[31:0];
            2'd1:    out_dat = hold_q[63:32];
            2'd2:    out_dat = hold_q[95:64];
            default: out_dat = hold_q[127:96];
        endcase
    end

    assign out_valid       = hold_full_q;
    assign fill_num        = fill_num_q;
    assign burst_start_adr = adr_q;
    assign num_fill_bursts = nfb_q;
    assign fill_type       = type_q;
    assign channel_tag     = tag_q;
    assign hdr_valid       = hdr_valid_q;
    assign fill_done       = fill_done_q;
    assign checksum_err    = checksum_err_q;
    assign reader_idle     = (state_q == S_IDLE);

endmodule

// File: tb/tb_adc_fill_reader.sv
// tb_adc_fill_reader
// ---------------------------------------------------------------------------
// Directed bench for adc_fill_reader. It uses two instances that share all
// inputs:
//   dut       CHECK_EN=1, FWD_HDR=1
//   dut_nochk CHECK_EN=0, FWD_HDR=1
//
// A queue models the FIFO. Each fill is expanded into the expected beat
// stream, header record and checksum verdict. The expected checksum is the
// XOR of the data words.
// ---------------------------------------------------------------------------
module tb_adc_fill_reader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         rd_abort;
    logic [127:0] in_dat;
    logic         in_valid;
    logic         out_ready;

    logic         in_rd, out_valid, hdr_valid, fill_done, checksum_err, reader_idle;
    logic [31:0]  out_dat;
    logic [23:0]  fill_num, num_fill_bursts;
    logic [22:0]  burst_start_adr;
    logic [1:0]   fill_type;
    logic [15:0]  channel_tag;

    logic         in_rd_b, out_valid_b, hdr_valid_b, fill_done_b, checksum_err_b, reader_idle_b;
    logic [31:0]  out_dat_b;
    logic [23:0]  fill_num_b, num_fill_bursts_b;
    logic [22:0]  burst_start_adr_b;
    logic [1:0]   fill_type_b;
    logic [15:0]  channel_tag_b;

    adc_fill_reader #(.CHECK_EN(1'b1), .FWD_HDR(1'b1)) dut (
        .clk(clk), .reset(reset), .rd_abort(rd_abort),
        .in_dat(in_dat), .in_valid(in_valid), .in_rd(in_rd),
        .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready),
        .fill_num(fill_num), .burst_start_adr(burst_start_adr),
        .num_fill_bursts(num_fill_bursts), .fill_type(fill_type),
        .channel_tag(channel_tag), .hdr_valid(hdr_valid), .fill_done(fill_done),
        .checksum_err(checksum_err), .reader_idle(reader_idle)
    );

    adc_fill_reader #(.CHECK_EN(1'b0), .FWD_HDR(1'b1)) dut_nochk (
        .clk(clk), .reset(reset), .rd_abort(rd_abort),
        .in_dat(in_dat), .in_valid(in_valid), .in_rd(in_rd_b),
        .out_dat(out_dat_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .fill_num(fill_num_b), .burst_start_adr(burst_start_adr_b),
        .num_fill_bursts(num_fill_bursts_b), .fill_type(fill_type_b),
        .channel_tag(channel_tag_b), .hdr_valid(hdr_valid_b), .fill_done(fill_done_b),
        .checksum_err(checksum_err_b), .reader_idle(reader_idle_b)
    );

    // ---------------- model state ----------------
    logic [127:0] fifo_q[$];
    logic [31:0]  exp_q[$];
    logic [127:0] exp_hdr_q[$];
    logic         exp_err_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int done_cnt_b = 0;
    int hdr_cnt = 0;
    int gap_at = -1;
    int gap_left = 0;
    int pops_in_fill = 0;
    int ready_mode = 0;
    logic [3:0] ready_pat = 4'b1001;
    logic pop_pending = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    logic t_arm = 1'b0;
    int first_inv_cyc = -1;
    int first_out_cyc = -1;
    int done_cyc = -1;
    logic [31:0] beat_log[64];

    localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_FFFF_1111_2222_3333_4444;
    localparam logic [127:0] D2 = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
    endtask

    // Build one fill: header, nb data words, trailer = XOR(data) ^ flip.
    task automatic push_fill(input logic [23:0] fnum, input logic [22:0] adr,
                             input logic [23:0] nb, input logic [1:0] typ,
                             input logic [15:0] tag, input logic [127:0] flip);
        logic [127:0] w[$];
        logic [127:0] hdr, acc, d;
        hdr = {39'h40_0000_0001, tag, typ, nb, adr, fnum};
        acc = '0;
        w.push_back(hdr);
        for (int i = 0; i < int'(nb); i++) begin
            d = (i == 0) ? D0 : (i == 1) ? D1 : D2;
            w.push_back(d);
            acc = acc ^ d;
        end
        w.push_back(acc ^ flip);
        foreach (w[j]) begin
            fifo_q.push_back(w[j]);
            for (int k = 0; k < 4; k++) exp_q.push_back(w[j][k*32 +: 32]);
        end
        exp_hdr_q.push_back(hdr);
        exp_err_q.push_back(flip != '0);
        pops_in_fill = 0;
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic compare();
        logic [127:0] h;
        logic e;
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_dat", out_dat, prev_dat);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                flag("extra_beat");
            end else begin
                check("beat_b_valid", out_valid_b, 1);
                check("beat_b", out_dat_b, exp_q[0]);
                check("beat", out_dat, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (xfer_cnt < 64) beat_log[xfer_cnt] = out_dat;
            xfer_cnt++;
        end
        if (hdr_valid) begin
            hdr_cnt++;
            check("hdr_excl_done", fill_done, 0);
            check("hdr_err_clr", checksum_err, 0);
            if (exp_hdr_q.size() == 0) begin
                flag("extra_hdr_valid");
            end else begin
                h = exp_hdr_q.pop_front();
                check("fill_num", fill_num, h[23:0]);
                check("burst_start_adr", burst_start_adr, h[46:24]);
                check("num_fill_bursts", num_fill_bursts, h[70:47]);
                check("fill_type", fill_type, h[72:71]);
                check("channel_tag", channel_tag, h[88:73]);
            end
        end
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_err_q.size() == 0) begin
                flag("extra_fill_done");
            end else begin
                e = exp_err_q.pop_front();
                check("checksum_err", checksum_err, e);
            end
        end
        if (fill_done_b) begin
            done_cnt_b++;
            check("checksum_err_nochk", checksum_err_b, 0);
        end
        if (gap_left > 0) check("gap_no_pop", in_rd, 0);
        if (t_arm) begin
            if (first_inv_cyc < 0 && in_valid) first_inv_cyc = cyc;
            if (first_out_cyc < 0 && out_valid) first_out_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_dat;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        in_valid = (fifo_q.size() > 0) && (gap_left == 0);
        in_dat   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic half_neg();
        @(negedge clk);
        cyc++;
        compare();
        pop_pending = in_rd && in_valid;
    endtask

    task automatic half_pos();
        @(posedge clk);
        #1;
        if (pop_pending) begin
            void'(fifo_q.pop_front());
            pops_in_fill++;
            if (pops_in_fill == gap_at) gap_left = 10;
        end else if (gap_left > 0) begin
            gap_left--;
        end
        pop_pending = 1'b0;
        out_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 4];
        drive();
    endtask

    task automatic tick();
        half_neg();
        half_pos();
    endtask

    task automatic run_fill(input int exp_xfers, input string name);
        int d0, d0b, t;
        xfer_cnt = 0;
        d0 = done_cnt;
        d0b = done_cnt_b;
        t = 0;
        while (done_cnt == d0 && t < 400) begin
            tick();
            t++;
        end
        if (done_cnt == d0) flag({name, "_timeout"});
        repeat (3) tick();
        check({name, "_xfers"}, 128'(xfer_cnt), 128'(exp_xfers));
        check({name, "_done_once"}, 128'(done_cnt - d0), 128'd1);
        check({name, "_done_once_nochk"}, 128'(done_cnt_b - d0b), 128'd1);
        check({name, "_beats_left"}, 128'(exp_q.size()), 128'd0);
        check({name, "_idle"}, reader_idle, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        reset = 1'b1;
        rd_abort = 1'b0;
        in_valid = 1'b1;
        in_dat = {4{32'hFFFF_FFFF}};
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rd", in_rd, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_idle", reader_idle, 1);
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_checksum_err", checksum_err, 0);
        check("rst_fill_num", fill_num, 0);
        check("rst_nfb", num_fill_bursts, 0);
        check("rst_out_dat", out_dat, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        in_dat = '0;
        repeat (2) tick();

        // T1: 3-burst fill, good checksum, out_ready held at 1.
        t_arm = 1'b1;
        first_inv_cyc = -1;
        first_out_cyc = -1;
        push_fill(24'h00ABCD, 23'h012345, 24'd3, 2'd2, 16'hBEEF, '0);
        drive();
        run_fill(20, "t1");
        t_arm = 1'b0;
        check("t1_first_beat_latency", 128'(first_out_cyc - first_inv_cyc), 128'd2);
        check("t1_back_to_back", 128'(done_cyc - first_out_cyc), 128'd20);
        check("t1_beat0_hdr_lsw", beat_log[0], 32'h4500_ABCD);
        check("t1_beat3_hdr_msw", beat_log[3], 32'h8000_0000);
        check("t1_beat4_d0_lsw", beat_log[4], 32'h7654_3210);
        check("t1_beat19_trl_msw", beat_log[19], 32'h7A2B_5E2D);
        check("t1_fill_num_lit", fill_num, 24'h00ABCD);
        check("t1_adr_lit", burst_start_adr, 23'h012345);
        check("t1_nfb_lit", num_fill_bursts, 24'd3);
        check("t1_type_lit", fill_type, 2'd2);
        check("t1_tag_lit", channel_tag, 16'hBEEF);
        check("t1_err_lit", checksum_err, 0);

        // T2: the same fill with trailer bit 0 flipped.
        push_fill(24'h00ABCE, 23'h012345, 24'd3, 2'd1, 16'h1234, 128'd1);
        drive();
        run_fill(20, "t2");
        check("t2_err_held", checksum_err, 1);
        check("t2_err_nochk", checksum_err_b, 0);

        // T3: zero-burst fill whose trailer is zero.
        push_fill(24'h000777, 23'h000001, 24'd0, 2'd0, 16'h0F0F, '0);
        drive();
        run_fill(8, "t3");
        check("t3_nfb_lit", num_fill_bursts, 24'd0);

        // T4: 2-burst fill with out_ready toggling 1,0,0,1.
        ready_mode = 1;
        push_fill(24'h000010, 23'h00ABCD, 24'd2, 2'd3, 16'hCAFE, '0);
        drive();
        run_fill(16, "t4");
        ready_mode = 0;

        // T5: in_valid is low for 10 cycles after D0 is popped.
        gap_at = 2;
        push_fill(24'h000020, 23'h000100, 24'd3, 2'd0, 16'h5555, '0);
        drive();
        run_fill(20, "t5");
        gap_at = -1;

        // T6: rd_abort while beat 2 of D1 is on the output.
        push_fill(24'h000030, 23'h000200, 24'd3, 2'd1, 16'hAAAA, '0);
        drive();
        xfer_cnt = 0;
        t = 0;
        while (xfer_cnt < 10 && t < 200) begin
            tick();
            t++;
        end
        if (xfer_cnt < 10) flag("t6_reach_timeout");
        rd_abort = 1'b1;
        half_neg();
        check("t6_abort_cycle_no_pop", in_rd, 0);
        @(posedge clk);
        #1;
        rd_abort = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        exp_hdr_q.delete();
        exp_err_q.delete();
        pop_pending = 1'b0;
        gap_left = 0;
        push_fill(24'h000123, 23'h000042, 24'd1, 2'd2, 16'h0123, '0);
        drive();
        half_neg();
        check("t6_post_out_valid", out_valid, 0);
        check("t6_post_idle", reader_idle, 1);
        check("t6_post_in_rd", in_rd, 0);
        check("t6_post_fill_num", fill_num, 0);
        half_pos();
        t = hdr_cnt;
        run_fill(12, "t6");
        check("t6_hdr_pulse", 128'(hdr_cnt - t), 128'd1);
        check("t6_fill_num_lit", fill_num, 24'h000123);
        check("t6_err_lit", checksum_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
